// File: rtl/avst_pixel_converter.sv
// rtl/avst_pixel_converter.sv - Avalon-ST RGB pixel converter with CSR slave and output FIFO (optional grayscale: AVST_PIXCONV_GRAY_EN)
module avst_pixel_converter #(
    parameter int IN_CW  = 8,
    parameter int OUT_RW = 5,
    parameter int OUT_GW = 6,
    parameter int OUT_BW = 5,
    parameter int DEPTH  = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [3:0]                       io_S_AVALON_address,
    output logic [31:0]                      io_S_AVALON_readdata,
    input  logic [31:0]                      io_S_AVALON_writedata,
    input  logic                             io_S_AVALON_write_n,
    input  logic                             io_S_AVALON_chipselect,
    input  logic [3*IN_CW-1:0]               io_in_data,
    input  logic                             io_in_startofpacket,
    input  logic                             io_in_endofpacket,
    input  logic [1:0]                       io_in_empty,
    input  logic                             io_in_valid,
    output logic                             io_in_ready,
    output logic [OUT_RW+OUT_GW+OUT_BW-1:0]  io_out_data,
    output logic                             io_out_startofpacket,
    output logic                             io_out_endofpacket,
    output logic                             io_out_empty,
    output logic                             io_out_valid,
    input  logic                             io_out_ready
);
    localparam int IN_W  = 3 * IN_CW;
    localparam int OUT_W = OUT_RW + OUT_GW + OUT_BW;
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = OUT_W + 2;

    typedef enum logic {S_IDLE, S_IN_FRAME} state_t;

    state_t             state_q;
    logic [2:0]         ctrl_q;
    logic [1:0]         mode_q;
    logic               trunc_q;
    logic [31:0]        frame_cnt_q;
    logic [31:0]        pixel_cnt_q;
    logic [31:0]        drop_cnt_q;
    logic [31:0]        readdata_q;
    logic [31:0]        rd_mux_d;

    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;

    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    logic               csr_wr;
    logic               csr_rd;
    logic [1:0]         eff_mode;
    logic [EW-1:0]      head;

    // Keeps deliberately ignored inputs referenced.
    logic               unused_sink;
    assign unused_sink = &{1'b0, io_in_empty, io_S_AVALON_writedata[31:3]};

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign csr_wr = io_S_AVALON_chipselect & ~io_S_AVALON_write_n;
    assign csr_rd = io_S_AVALON_chipselect &  io_S_AVALON_write_n;

    // A started frame always drains even if EN is cleared; IDLE needs EN.
    assign io_in_ready = ~full & ((state_q == S_IN_FRAME) | ctrl_q[0]);
    assign accept      = io_in_valid & io_in_ready;
    assign drop        = accept & (state_q == S_IDLE) & ~io_in_startofpacket;
    assign push        = accept & ~drop;
    assign pop         = ~empty & io_out_ready;

    // SOP beats use the mode being latched on that same beat.
    assign eff_mode = io_in_startofpacket ? ctrl_q[2:1] : mode_q;

    // Channel split, R in the MSBs.
    logic [IN_CW-1:0] r_c, g_c, b_c;
    assign r_c = io_in_data[IN_W-1 -: IN_CW];
    assign g_c = io_in_data[2*IN_CW-1 -: IN_CW];
    assign b_c = io_in_data[IN_CW-1 -: IN_CW];

    // Pack: append zeros on the right, then keep the top bits of each channel.
    logic [IN_CW+OUT_RW-1:0] pr_ext;
    logic [IN_CW+OUT_GW-1:0] pg_ext;
    logic [IN_CW+OUT_BW-1:0] pb_ext;
    logic [OUT_W-1:0]        pack_data;
    assign pr_ext    = {r_c, {OUT_RW{1'b0}}};
    assign pg_ext    = {g_c, {OUT_GW{1'b0}}};
    assign pb_ext    = {b_c, {OUT_BW{1'b0}}};
    assign pack_data = {pr_ext[IN_CW+OUT_RW-1 -: OUT_RW],
                        pg_ext[IN_CW+OUT_GW-1 -: OUT_GW],
                        pb_ext[IN_CW+OUT_BW-1 -: OUT_BW]};

    // Pass: low OUT_W bits of the input word, zero-extended if the input is narrower.
    logic [OUT_W+IN_W-1:0] pass_ext;
    logic [OUT_W-1:0]      pass_data;
    assign pass_ext  = {{OUT_W{1'b0}}, io_in_data};
    assign pass_data = pass_ext[OUT_W-1:0];

    logic [OUT_W-1:0] gray_data;
`ifdef AVST_PIXCONV_GRAY_EN
    // Gray: BT.601-style luma on the top 8 bits of each channel, replicated.
    logic [IN_CW+7:0]  r8_ext, g8_ext, b8_ext;
    logic [7:0]        r8, g8, b8, y8;
    logic [15:0]       y_sum;
    logic [OUT_RW+7:0] yr_ext;
    logic [OUT_GW+7:0] yg_ext;
    logic [OUT_BW+7:0] yb_ext;
    assign r8_ext    = {r_c, 8'd0};
    assign g8_ext    = {g_c, 8'd0};
    assign b8_ext    = {b_c, 8'd0};
    assign r8        = r8_ext[IN_CW+7 -: 8];
    assign g8        = g8_ext[IN_CW+7 -: 8];
    assign b8        = b8_ext[IN_CW+7 -: 8];
    assign y_sum     = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    assign y8        = y_sum[15:8];
    assign yr_ext    = {y8, {OUT_RW{1'b0}}};
    assign yg_ext    = {y8, {OUT_GW{1'b0}}};
    assign yb_ext    = {y8, {OUT_BW{1'b0}}};
    assign gray_data = {yr_ext[OUT_RW+7 -: OUT_RW],
                        yg_ext[OUT_GW+7 -: OUT_GW],
                        yb_ext[OUT_BW+7 -: OUT_BW]};
`else
    assign gray_data = pack_data;
`endif

    logic [OUT_W-1:0] conv_data;
    // Select the conversion for the beat being pushed.
    always_comb begin
        conv_data = pack_data;
        case (eff_mode)
            2'd1:    conv_data = gray_data;
            2'd2:    conv_data = pass_data;
            default: conv_data = pack_data;
        endcase
    end

    // Input framing FSM: mode latch on SOP and sticky truncation flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            trunc_q <= 1'b0;
        end else begin
            if (accept) begin
                if (io_in_startofpacket) begin
                    mode_q <= ctrl_q[2:1];
                end
                case (state_q)
                    S_IDLE: begin
                        if (io_in_startofpacket && !io_in_endofpacket) begin
                            state_q <= S_IN_FRAME;
                        end
                    end
                    default: begin
                        if (io_in_endofpacket) begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
            if (csr_wr && io_S_AVALON_address == 4'd1) begin
                trunc_q <= 1'b0;
            end else if (accept && state_q == S_IN_FRAME && io_in_startofpacket) begin
                trunc_q <= 1'b1;
            end
        end
    end

    // Control register and statistics counters; a CSR clear beats an increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q      <= 3'd0;
            frame_cnt_q <= 32'd0;
            pixel_cnt_q <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            if (csr_wr && io_S_AVALON_address == 4'd0) begin
                ctrl_q <= io_S_AVALON_writedata[2:0];
            end
            if (csr_wr && io_S_AVALON_address == 4'd2) begin
                frame_cnt_q <= 32'd0;
            end else if (pop && head[EW-2]) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (pop) begin
                pixel_cnt_q <= head[EW-1] ? 32'd1 : pixel_cnt_q + 32'd1;
            end
            if (csr_wr && io_S_AVALON_address == 4'd4) begin
                drop_cnt_q <= 32'd0;
            end else if (drop && drop_cnt_q != 32'hFFFF_FFFF) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    // CSR read multiplexer.
    always_comb begin
        rd_mux_d = 32'd0;
        case (io_S_AVALON_address)
            4'd0:    rd_mux_d = {29'd0, ctrl_q};
            4'd1:    rd_mux_d = {28'd0, trunc_q, empty, full, state_q == S_IN_FRAME};
            4'd2:    rd_mux_d = frame_cnt_q;
            4'd3:    rd_mux_d = pixel_cnt_q;
            4'd4:    rd_mux_d = drop_cnt_q;
            default: rd_mux_d = 32'd0;
        endcase
    end

    // Registered read data, updated only on a read access.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q <= 32'd0;
        end else if (csr_rd) begin
            readdata_q <= rd_mux_d;
        end
    end

    // FIFO storage; contents are masked at the outputs while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {io_in_startofpacket, io_in_endofpacket, conv_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head                 = empty ? '0 : mem_q[rd_ptr_q];
    assign io_out_valid         = ~empty;
    assign io_out_startofpacket = head[EW-1];
    assign io_out_endofpacket   = head[EW-2];
    assign io_out_data          = head[OUT_W-1:0];
    assign io_out_empty         = 1'b0;
    assign io_S_AVALON_readdata = readdata_q;

endmodule

// File: tb/tb_avst_pixel_converter.sv
// tb/tb_avst_pixel_converter.sv - directed scoreboard bench for avst_pixel_converter
`timescale 1ns/1ps
module tb_avst_pixel_converter;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic [31:0] readdata;
    logic [31:0] writedata;
    logic        write_n;
    logic        chipselect;
    logic [23:0] in_data;
    logic        in_sop, in_eop, in_valid, in_ready;
    logic [1:0]  in_empty;
    logic [15:0] out_data;
    logic        out_sop, out_eop, out_empty, out_valid, out_ready;

    int compared   = 0;
    int mismatched = 0;
    logic [17:0] exp_q[$];

    avst_pixel_converter dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_S_AVALON_address    (address),
        .io_S_AVALON_readdata   (readdata),
        .io_S_AVALON_writedata  (writedata),
        .io_S_AVALON_write_n    (write_n),
        .io_S_AVALON_chipselect (chipselect),
        .io_in_data             (in_data),
        .io_in_startofpacket    (in_sop),
        .io_in_endofpacket      (in_eop),
        .io_in_empty            (in_empty),
        .io_in_valid            (in_valid),
        .io_in_ready            (in_ready),
        .io_out_data            (out_data),
        .io_out_startofpacket   (out_sop),
        .io_out_endofpacket     (out_eop),
        .io_out_empty           (out_empty),
        .io_out_valid           (out_valid),
        .io_out_ready           (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RGB565 reference model.
    function automatic logic [15:0] conv(input logic [1:0] m, input logic [23:0] d);
        logic [7:0]  r, g, b, y;
        logic [15:0] s;
        r = d[23:16]; g = d[15:8]; b = d[7:0];
        s = 16'(77 * r + 150 * g + 29 * b);
        y = s[15:8];
        case (m)
            2'd2: return d[15:0];
`ifdef AVST_PIXCONV_GRAY_EN
            2'd1: return {y[7:3], y[7:2], y[7:3]};
`endif
            default: return {r[7:3], g[7:2], b[7:3]};
        endcase
    endfunction

    // Scoreboard: every output handshake pops and compares one expected beat.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_output observed=0x%0h expected=none", {out_sop, out_eop, out_data});
            end
            if (exp_q.size() != 0) begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("out_beat", {14'd0, out_sop, out_eop, out_data}, {14'd0, e});
            end
        end
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write_n = 1'b0; chipselect = 1'b1;
        @(posedge clock); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        address = a; write_n = 1'b1; chipselect = 1'b1;
        @(posedge clock); #1;
        chipselect = 1'b0;
        d = readdata;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic s, input logic e,
                             input logic expect_out, input logic [1:0] m);
        logic done;
        done = 1'b0;
        in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock); #1;
                done = 1'b1;
                if (expect_out) exp_q.push_back({s, e, conv(m, d)});
                break;
            end
        end
        in_valid = 1'b0;
        check("beat_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain", exp_q.size(), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [23:0] d6 [6];
        int          hi;
        reset = 1'b1; address = 4'd0; writedata = 32'd0; write_n = 1'b1; chipselect = 1'b0;
        in_data = 24'd0; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0; in_empty = 2'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sop_eop_data", {14'd0, out_sop, out_eop, out_data}, 32'd0);
        check("rst_out_empty", {31'd0, out_empty}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        csr_read(4'd0, rd); check("rst_ctrl", rd, 32'd0);
        csr_read(4'd1, rd); check("rst_status", rd, 32'h4);
        csr_read(4'd2, rd); check("rst_frame_cnt", rd, 32'd0);
        csr_read(4'd3, rd); check("rst_pixel_cnt", rd, 32'd0);
        csr_read(4'd4, rd); check("rst_drop_cnt", rd, 32'd0);
        csr_read(4'd9, rd); check("unmapped_read", rd, 32'd0);

        // Basic pack frame
        out_ready = 1'b1;
        csr_write(4'd0, 32'h1);
        send_beat(24'hFF0000, 1'b1, 1'b0, 1'b1, 2'd0);
        send_beat(24'h00FF00, 1'b0, 1'b0, 1'b1, 2'd0);
        send_beat(24'h0000FF, 1'b0, 1'b1, 1'b1, 2'd0);
        wait_drain();
        csr_read(4'd2, rd); check("frame_cnt_1", rd, 32'd1);
        csr_read(4'd3, rd); check("pixel_cnt_3", rd, 32'd3);

        // EN=0 blocks input; non-SOP beats in IDLE are dropped
        csr_write(4'd0, 32'h0);
        in_data = 24'h123456; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (in_ready) hi++;
        end
        check("en0_in_ready_low", hi, 32'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        csr_write(4'd0, 32'h1);
        for (int i = 0; i < 5; i++) send_beat(24'h010203 * (i + 1), 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (3) @(posedge clock); #1;
        csr_read(4'd4, rd); check("drop_cnt_5", rd, 32'd5);
        csr_write(4'd4, 32'd0);
        csr_read(4'd4, rd); check("drop_cnt_clear", rd, 32'd0);

        // Backpressure: 6-beat frame into a 4-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) d6[i] = 24'($urandom);
        for (int i = 0; i < 4; i++) send_beat(d6[i], i == 0, 1'b0, 1'b1, 2'd0);
        @(negedge clock);
        check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        csr_read(4'd1, rd); check("status_full", rd & 32'h7, 32'h3);
        out_ready = 1'b1;
        @(negedge clock);
        check("full_pop_bubble", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        send_beat(d6[4], 1'b0, 1'b0, 1'b1, 2'd0);
        send_beat(d6[5], 1'b0, 1'b1, 1'b1, 2'd0);
        wait_drain();
        csr_read(4'd3, rd); check("pixel_cnt_6", rd, 32'd6);
        csr_read(4'd2, rd); check("frame_cnt_2", rd, 32'd2);

        // Mode 1 (gray when enabled, pack otherwise)
        csr_write(4'd0, 32'h3);
        csr_read(4'd0, rd); check("ctrl_readback", rd, 32'h3);
        send_beat(24'h808080, 1'b1, 1'b0, 1'b1, 2'd1);
        send_beat(24'hFF0000, 1'b0, 1'b1, 1'b1, 2'd1);
        wait_drain();

        // Truncation and mid-frame mode change
        csr_write(4'd0, 32'h1);
        send_beat(24'h11AA55, 1'b1, 1'b0, 1'b1, 2'd0);
        send_beat(24'h2233CC, 1'b0, 1'b0, 1'b1, 2'd0);
        send_beat(24'hF0F0F0, 1'b1, 1'b0, 1'b1, 2'd0);
        csr_read(4'd1, rd); check("trunc_in_frame", rd & 32'h9, 32'h9);
        csr_write(4'd1, 32'd0);
        csr_read(4'd1, rd); check("trunc_cleared", rd & 32'h8, 32'h0);
        csr_write(4'd0, 32'h5);
        send_beat(24'h0F1E2D, 1'b0, 1'b0, 1'b1, 2'd0);
        send_beat(24'hABCDEF, 1'b0, 1'b1, 1'b1, 2'd0);
        send_beat(24'h123456, 1'b1, 1'b1, 1'b1, 2'd2);
        wait_drain();
        csr_read(4'd1, rd); check("idle_after_frame", rd & 32'h1, 32'h0);
        csr_read(4'd2, rd); check("frame_cnt_5", rd, 32'd5);
        csr_read(4'd3, rd); check("pixel_cnt_single", rd, 32'd1);
        csr_write(4'd2, 32'd0);
        csr_read(4'd2, rd); check("frame_cnt_clear", rd, 32'd0);

        // Reset mid-frame with the FIFO half full
        out_ready = 1'b0;
        csr_write(4'd0, 32'h1);
        send_beat(24'hAAAAAA, 1'b1, 1'b0, 1'b1, 2'd0);
        send_beat(24'h555555, 1'b0, 1'b0, 1'b1, 2'd0);
        csr_read(4'd1, rd); check("pre_reset_status", rd, 32'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_reset_out_data", {14'd0, out_sop, out_eop, out_data}, 32'd0);
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("post_reset_readdata", readdata, 32'd0);
        csr_read(4'd1, rd); check("post_reset_status", rd, 32'h4);
        csr_read(4'd0, rd); check("post_reset_ctrl", rd, 32'd0);
        csr_read(4'd3, rd); check("post_reset_pixel_cnt", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
